// File: rtl/msft_dvip_clken_gen.sv
// msft_dvip_clken_gen: run-time programmable clock-enable generator.
// NUM_CH phase-aligned enable trains from sysClk_i, one divisor each.
//
// Ports:
//   sysClk_i    system clock (only clock)
//   RESET_i     synchronous active-high reset
//   cfgValid_i  config request
//   cfgReady_o  config accept, high while locked
//   cfgCh_i     target channel
//   cfgDiv_i    new divisor (0 stops the channel)
//   cfgErr_o    one-cycle pulse: accepted request hit a bad channel
//   chEnable_i  per-channel output gate (combinational mask)
//   clkEn_o     per-channel enable pulses
//   locked_o    enables valid and phase-aligned
module msft_dvip_clken_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sysClk_i,
  input  logic              RESET_i,
  input  logic              cfgValid_i,
  output logic              cfgReady_o,
  input  logic [CH_W-1:0]   cfgCh_i,
  input  logic [DIV_W-1:0]  cfgDiv_i,
  output logic              cfgErr_o,
  input  logic [NUM_CH-1:0] chEnable_i,
  output logic [NUM_CH-1:0] clkEn_o,
  output logic              locked_o
);

  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [LC_W-1:0] LOCK_LAST =
    LC_W'(LOCK_CYCLES - 1);
  localparam logic [LC_W-1:0] LC_ONE = LC_W'(1);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  localparam logic [CH_W:0] NUM_CH_C = (CH_W + 1)'(NUM_CH);

  localparam logic [0:0] ST_WAIT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic [LC_W-1:0] lockCnt_q;
  logic [LC_W-1:0] lockCnt_d;
  logic            cfgErr_q;
  logic            cfgErr_d;

  logic [NUM_CH-1:0][DIV_W-1:0] div_q;
  logic [NUM_CH-1:0][DIV_W-1:0] div_d;
  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q;
  logic [NUM_CH-1:0][DIV_W-1:0] cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0] divM1;
  logic [NUM_CH-1:0]            hit;

  logic locked;
  logic xfer;
  logic chOk;
  logic relock;

  assign locked = (state_q == ST_LOCKED);
  assign xfer   = cfgValid_i && locked;
  assign chOk   = ({1'b0, cfgCh_i} < NUM_CH_C);
  assign relock = xfer && chOk;

  always_comb begin
    state_d   = state_q;
    lockCnt_d = lockCnt_q;
    cfgErr_d  = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (lockCnt_q == LOCK_LAST) begin
          state_d   = ST_LOCKED;
          lockCnt_d = '0;
        end else begin
          lockCnt_d = lockCnt_q + LC_ONE;
        end
      end
      ST_LOCKED: begin
        if (relock) begin
          state_d   = ST_WAIT;
          lockCnt_d = '0;
        end else if (xfer) begin
          cfgErr_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    div_d = div_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (relock && cfgCh_i == CH_W'(i)) begin
        div_d[i] = cfgDiv_i;
      end
    end
  end

  // Counters sit at 0 outside LOCKED so every channel
  // restarts from a common epoch after each relock.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      divM1[i] = div_q[i] - DIV_ONE;
      hit[i]   = (div_q[i] != '0) && (cnt_q[i] == divM1[i]);
      if (!locked || relock) begin
        cnt_d[i] = '0;
      end else if (div_q[i] == '0 || hit[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_ONE;
      end
    end
  end

  always_ff @(posedge sysClk_i) begin
    if (RESET_i) begin
      state_q   <= ST_WAIT;
      lockCnt_q <= '0;
      cfgErr_q  <= 1'b0;
      div_q     <= {NUM_CH{DIV_RST}};
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lockCnt_q <= lockCnt_d;
      cfgErr_q  <= cfgErr_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
    end
  end

  // Gate is combinational so chEnable_i masks in the same cycle
  // while the counters keep their phase.
  assign clkEn_o    = locked ? (chEnable_i & hit) : '0;
  assign locked_o   = locked;
  assign cfgReady_o = locked;
  assign cfgErr_o   = cfgErr_q;

endmodule

// File: doc/msft_dvip_clken_gen.md
# msft_dvip_clken_gen

Parametrised clock-enable generator for the Arty7 platform. It is the run-time-programmable successor to the fixed-ratio MMCM clock wrapper. From one system clock it produces NUM_CH phase-aligned clock-enable pulse trains, each with its own divisor. Divisors are reprogrammed through a valid/ready port, and each reprogram is followed by a relock interval with a locked indication. It sits beside the MMCM wrapper and drives slow peripheral logic, such as UART, timers and SPI, which runs on the fast clock qualified by these enables.

## Interface
- NUM_CH, 4: number of enable channels, 1..16.
- DIV_W, 8: divisor width per channel.
- DEFAULT_DIV, 5: reset divisor for every channel, 0..2^DIV_W-1.
- LOCK_CYCLES, 16: relock interval in cycles, >=1.
- CH_W, derived = max(1,$clog2(NUM_CH)).

Ports:
- sysClk_i  in  1  system clock; the only clock in the block.
- RESET_i  in  1  reset, synchronous to sysClk_i, active-high.
- cfgValid_i  in  1  config request.
- cfgReady_o  out  1  config accept; high only in LOCKED.
- cfgCh_i  in  CH_W  target channel.
- cfgDiv_i  in  DIV_W  new divisor; 0 = channel stopped.
- cfgErr_o  out  1  one-cycle pulse: accepted request had cfgCh_i >= NUM_CH.
- chEnable_i  in  NUM_CH  per-channel output gate.
- clkEn_o  out  NUM_CH  per-channel enable pulses.
- locked_o  out  1  enables valid and phase-aligned.

## Operation
- Per channel state: divisor register div[i] and counter cnt[i] of DIV_W bits.
- Block state: FSM state and lock counter lockCnt of $clog2(LOCK_CYCLES+1) bits.
- FSM states:
  - WAIT: every cnt held at 0, clkEn_o=0, locked_o=0, cfgReady_o=0. lockCnt increments each cycle. When lockCnt==LOCK_CYCLES-1 the FSM goes to LOCKED and lockCnt clears.
  - LOCKED: locked_o=1, cfgReady_o=1. Each cnt[i] with div[i]!=0 counts 0..div[i]-1 and wraps.
- clkEn_o[i] = LOCKED && chEnable_i[i] && div[i]!=0 && cnt[i]==div[i]-1. This is a decode of registers plus chEnable_i only.
- chEnable_i only masks the output; counters keep running, so phase is preserved across gating.
- Config handshake: a transfer occurs when cfgValid_i && cfgReady_o are high at a sysClk_i edge.
  - cfgCh_i < NUM_CH: div[cfgCh_i] ← cfgDiv_i, FSM → WAIT, lockCnt ← 0. All channels realign, not just the written one.
  - cfgCh_i >= NUM_CH: no write, no relock, cfgErr_o=1 for the next cycle.
- cfgValid_i held high during WAIT is not accepted. The requester must hold its data until cfgReady_o is high.
- div=1: the enable is high every LOCKED cycle. div=0: the counter is frozen at 0 and no pulses are produced.

## Timing
- Reset values while RESET_i=1:
  - All div ← DEFAULT_DIV, all cnt ← 0, FSM ← WAIT, lockCnt ← 0.
  - Outputs: clkEn_o=0, locked_o=0, cfgReady_o=0, cfgErr_o=0.
- Cycle numbering: cycle 0 is the first cycle with RESET_i=0. locked_o first goes high in cycle LOCK_CYCLES.
- Transfer at the end of cycle c: locked_o is low in cycles c+1..c+LOCK_CYCLES and high from c+LOCK_CYCLES+1.
- If L is the first cycle with locked_o=1, clkEn_o[i] is high in cycles L+k·div[i]-1, k=1,2,…. All channels therefore share the epoch L.
- Counter wrap: from cnt=div-1 the next value is 0. Wrap is unaffected by DIV_W overflow, since div ≤ 2^DIV_W-1.
- RESET_i asserted mid-WAIT or mid-LOCKED: the next cycle has reset values, and any pending cfgValid_i is dropped.
- Latency from a RESET_i or cfgValid_i change to outputs is one edge.
- A change on chEnable_i affects clkEn_o in the same cycle, through combinational gating.

## Test plan
- Reset release, defaults (DEFAULT_DIV=5, LOCK_CYCLES=16):
  - locked_o rises in cycle 16 and cfgReady_o rises with it.
  - clkEn_o[0..3] pulse in cycles 20, 25, 30.
- Reprogram ch2 to 3 at the end of cycle 40:
  - locked_o is low in cycles 41..56 and all clkEn_o are 0 there.
  - From cycle 57, ch2 pulses at 59, 62, … and the other channels at 61, 66, ….
- Boundary divisors:
  - div=1: clkEn_o is high every LOCKED cycle.
  - div=0: clkEn_o stays 0 indefinitely.
  - div=255 (DIV_W=8): a pulse every 255th cycle, with correct wrap to 0.
- Handshake with NUM_CH=3:
  - cfgCh_i=3 with cfgValid_i in LOCKED gives a cfgErr_o pulse, locked_o stays 1 and divisors are unchanged.
  - cfgValid_i held during WAIT is accepted only on the first LOCKED cycle.
- Gating: chEnable_i[1] low for 12 cycles masks ch1 pulses. After re-enable, pulses land on the original k·div grid with no phase shift.
- Reset mid-WAIT, 5 cycles into a relock:
  - All div return to 5.
  - locked_o rises exactly 16 cycles after RESET_i falls.
